multicycle_control: RTL and testbench

- Multi-cycle sequencer for the 16-bit, 4-register datapath. Splits each instruction into FETCH / DECODE / EXEC / WB so the datapath can share one ALU between PC increment, branch target and execute.
- Handshakes with a variable-latency instruction memory.
- Drives all datapath enables and mux selects, and the ALU operation code directly; no separate ALU control unit is needed.
- Halts on an illegal opcode or an instruction-fetch timeout.

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer; 3-4 cycles per instruction plus imem wait cycles.
// Stalls in FETCH until imem_ack, halting on timeout or illegal opcode; `BEQ_EN adds the beq opcode.
module multicycle_control #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] op,
    input  logic       imem_ack,
    input  logic       zero,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic       aluout_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC_R = 3'd2,
        S_EXEC_I = 3'd3,
        S_WB_R   = 3'd4,
        S_WB_I   = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       imem_req_c, ir_write_c, pc_write_c, pc_src_c, alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] alu_ctl_c;
    logic       aluout_write_c, reg_dst_c, reg_write_c;

`ifndef BEQ_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = '0;
        illegal_d      = illegal_q;
        timeout_d      = timeout_q;
        imem_req_c     = 1'b0;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        pc_src_c       = 1'b0;
        alu_src_a_c    = 1'b0;
        alu_src_b_c    = 2'b00;
        alu_ctl_c      = 3'b000;
        aluout_write_c = 1'b0;
        reg_dst_c      = 1'b0;
        reg_write_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_ctl_c   = ALU_ADD;
                ir_write_c  = imem_ack;
                pc_write_c  = imem_ack;
                // An ack on the last allowed cycle takes priority over the timeout.
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (ACK_TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed unconditionally into ALUOut.
                alu_src_b_c    = 2'b11;
                alu_ctl_c      = ALU_ADD;
                aluout_write_c = 1'b1;
                case (op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = S_EXEC_R;
                    4'b0100: state_d = S_EXEC_I;
`ifdef BEQ_EN
                    4'b0101: state_d = S_BRANCH;
`endif
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_c    = 1'b1;
                aluout_write_c = 1'b1;
                case (op)
                    4'b0001: alu_ctl_c = ALU_SUB;
                    4'b0010: alu_ctl_c = ALU_AND;
                    4'b0011: alu_ctl_c = ALU_OR;
                    4'b0111: alu_ctl_c = ALU_SLT;
                    default: alu_ctl_c = ALU_ADD;
                endcase
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a_c    = 1'b1;
                alu_src_b_c    = 2'b10;
                alu_ctl_c      = ALU_ADD;
                aluout_write_c = 1'b1;
                state_d        = S_WB_I;
            end
            S_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_WB_I: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
`ifdef BEQ_EN
                alu_src_a_c = 1'b1;
                alu_ctl_c   = ALU_SUB;
                pc_src_c    = 1'b1;
                pc_write_c  = zero;
`endif
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Reset gates outputs combinationally so no write strobe survives resetn falling.
    assign imem_req     = resetn & imem_req_c;
    assign ir_write     = resetn & ir_write_c;
    assign pc_write     = resetn & pc_write_c;
    assign pc_src       = resetn & pc_src_c;
    assign alu_src_a    = resetn & alu_src_a_c;
    assign alu_src_b    = resetn ? alu_src_b_c : 2'b00;
    assign alu_ctl      = resetn ? alu_ctl_c : 3'b000;
    assign aluout_write = resetn & aluout_write_c;
    assign reg_dst      = resetn & reg_dst_c;
    assign reg_write    = resetn & reg_write_c;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default instance plus an ACK_TIMEOUT=3 instance.
module tb_multicycle_control;

    logic       clock;
    logic       resetn, resetn2;
    logic [3:0] op;
    logic       imem_ack, imem_ack2;
    logic       zero;

    logic       imem_req, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       aluout_write, reg_dst, reg_write, illegal, timeout;
    logic [2:0] state;

    logic       imem_req2, ir_write2, pc_write2, pc_src2, alu_src_a2;
    logic [1:0] alu_src_b2;
    logic [2:0] alu_ctl2;
    logic       aluout_write2, reg_dst2, reg_write2, illegal2, timeout2;
    logic [2:0] state2;

    logic [17:0] outs;
    assign outs = {imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctl,
                   aluout_write, reg_dst, reg_write, illegal, timeout, state};

    int n_cmp = 0;
    int n_fail = 0;
    int req_cnt, wr_cnt, pw_cnt;

    multicycle_control dut (
        .clock(clock), .resetn(resetn), .op(op), .imem_ack(imem_ack), .zero(zero),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
        .aluout_write(aluout_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .illegal(illegal), .timeout(timeout), .state(state)
    );

    multicycle_control #(.ACK_TIMEOUT(3)) dut_to (
        .clock(clock), .resetn(resetn2), .op(op), .imem_ack(imem_ack2), .zero(zero),
        .imem_req(imem_req2), .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_ctl(alu_ctl2),
        .aluout_write(aluout_write2), .reg_dst(reg_dst2), .reg_write(reg_write2),
        .illegal(illegal2), .timeout(timeout2), .state(state2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, apply inputs at the falling edge, settle.
    task automatic cyc(input logic ack_v, input logic [3:0] op_v);
        @(negedge clock);
        imem_ack = ack_v;
        op       = op_v;
        #1;
    endtask

    initial begin
        logic [3:0] r_ops [4];
        logic [2:0] r_ctl [4];
        r_ops = '{4'b0000, 4'b0010, 4'b0011, 4'b0111};
        r_ctl = '{3'b010, 3'b000, 3'b001, 3'b111};

        resetn = 0; resetn2 = 0; imem_ack = 0; imem_ack2 = 0; op = 4'b0000; zero = 0;
        #1 chk("reset_outputs", 32'(outs), 32'h0);

        @(negedge clock); resetn = 1; #1;
        chk("release_req", 32'(imem_req), 1);
        chk("release_state", 32'(state), 0);

        // addi, ack in first FETCH cycle
        imem_ack = 1; op = 4'b0100; #1;
        chk("addi_fetch_irw", 32'(ir_write), 1);
        chk("addi_fetch_pcw", 32'(pc_write), 1);
        chk("addi_fetch_srcb", 32'(alu_src_b), 32'b01);
        cyc(0, 4'b0100);
        chk("addi_decode_state", 32'(state), 1);
        chk("addi_decode_srcb", 32'(alu_src_b), 32'b11);
        chk("addi_decode_aluout", 32'(aluout_write), 1);
        cyc(0, 4'b0100);
        chk("addi_exec_state", 32'(state), 3);
        chk("addi_exec_srcb", 32'(alu_src_b), 32'b10);
        chk("addi_exec_ctl", 32'(alu_ctl), 32'b010);
        chk("addi_exec_srca", 32'(alu_src_a), 1);
        cyc(0, 4'b0100);
        chk("addi_wb_state", 32'(state), 5);
        chk("addi_wb_regw", 32'(reg_write), 1);
        chk("addi_wb_regdst", 32'(reg_dst), 0);

        // sub with ack on the fourth FETCH cycle
        req_cnt = 0; wr_cnt = 0; pw_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(i == 3, 4'b0001);
            req_cnt += int'(imem_req);
            wr_cnt  += int'(ir_write);
            pw_cnt  += int'(pc_write);
        end
        chk("sub_req_cycles", 32'(req_cnt), 4);
        chk("sub_irw_pulses", 32'(wr_cnt), 1);
        chk("sub_pcw_pulses", 32'(pw_cnt), 1);
        chk("sub_exec_state", 32'(state), 2);
        chk("sub_exec_ctl", 32'(alu_ctl), 32'b110);
        chk("sub_exec_srcb", 32'(alu_src_b), 32'b00);
        cyc(0, 4'b0001);
        chk("sub_wb_state", 32'(state), 4);
        chk("sub_wb_regdst", 32'(reg_dst), 1);
        chk("sub_wb_regw", 32'(reg_write), 1);

        // remaining R-type ALU codes
        for (int k = 0; k < 4; k++) begin
            cyc(1, r_ops[k]);
            chk("rtype_fetch_state", 32'(state), 0);
            cyc(0, r_ops[k]);
            cyc(0, r_ops[k]);
            chk("rtype_exec_state", 32'(state), 2);
            chk("rtype_exec_ctl", 32'(alu_ctl), 32'(r_ctl[k]));
            cyc(0, r_ops[k]);
            chk("rtype_wb_state", 32'(state), 4);
        end

        // reset asserted while in EXEC_R
        cyc(1, 4'b0000);
        cyc(0, 4'b0000);
        cyc(0, 4'b0000);
        chk("midrst_pre_state", 32'(state), 2);
        resetn = 0; #1;
        chk("midrst_outputs", 32'(outs), 32'h0);
        @(negedge clock); resetn = 1; #1;
        chk("midrst_release_req", 32'(imem_req), 1);

        // beq
        imem_ack = 1; op = 4'b0101; #1;
        cyc(0, 4'b0101);
        chk("beq_decode_state", 32'(state), 1);
`ifdef BEQ_EN
        zero = 1;
        cyc(0, 4'b0101);
        chk("beq_taken_state", 32'(state), 6);
        chk("beq_taken_pcw", 32'(pc_write), 1);
        chk("beq_taken_pcsrc", 32'(pc_src), 1);
        chk("beq_taken_ctl", 32'(alu_ctl), 32'b110);
        cyc(0, 4'b0101);
        chk("beq_latency_state", 32'(state), 0);
        imem_ack = 1; #1;
        cyc(0, 4'b0101);
        zero = 0;
        cyc(0, 4'b0101);
        chk("beq_nt_state", 32'(state), 6);
        chk("beq_nt_pcw", 32'(pc_write), 0);
        cyc(0, 4'b0101);
`else
        cyc(0, 4'b0101);
        chk("beq_off_state", 32'(state), 7);
        chk("beq_off_illegal", 32'(illegal), 1);
        chk("beq_off_pcsrc", 32'(pc_src), 0);
        resetn = 0;
        @(negedge clock); resetn = 1; #1;
`endif

        // illegal opcode 1010
        imem_ack = 1; op = 4'b1010; #1;
        cyc(0, 4'b1010);
        cyc(0, 4'b1010);
        chk("illegal_state", 32'(state), 7);
        chk("illegal_flag", 32'(illegal), 1);
        req_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(i % 2 == 0, 4'b1010);
            req_cnt += int'(imem_req);
            wr_cnt  += int'(ir_write);
        end
        chk("halt_req_cycles", 32'(req_cnt), 0);
        chk("halt_irw_pulses", 32'(wr_cnt), 0);
        chk("halt_state_held", 32'(state), 7);
        resetn = 0; imem_ack = 0; #1;
        chk("illegal_cleared", 32'(illegal), 0);
        @(negedge clock); resetn = 1; #1;

        // timeout with ACK_TIMEOUT = 3
        @(negedge clock); resetn2 = 1; imem_ack2 = 0;
        req_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1 req_cnt += int'(imem_req2);
            @(negedge clock);
        end
        #1;
        chk("to_req_cycles", 32'(req_cnt), 3);
        chk("to_state", 32'(state2), 7);
        chk("to_flag", 32'(timeout2), 1);
        resetn2 = 0; #1;
        chk("to_cleared", 32'(timeout2), 0);
        @(negedge clock); resetn2 = 1; imem_ack2 = 0;
        @(negedge clock); imem_ack2 = 0;
        @(negedge clock); imem_ack2 = 1; #1;
        chk("to_last_ack_irw", 32'(ir_write2), 1);
        @(negedge clock); imem_ack2 = 0; #1;
        chk("to_last_ack_state", 32'(state2), 1);
        chk("to_last_ack_flag", 32'(timeout2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
